// File: rtl/pipe_addsub_pkg.sv
// Shared configuration for the pipelined adder/subtractor: default geometry,
// derived chunk width and a helper used to reject illegal geometries.
package pipe_addsub_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;
    localparam int CW             = DEFAULT_WIDTH / DEFAULT_STAGES;

    // A geometry is legal when every stage owns an equal, non-empty slice.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// Combinational CW-bit ripple-carry slice built from full-adder cells.
// Also exposes the carry into its MSB so the top slice can derive overflow.
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          cm
);

    logic carry;

    // Ripple the carry LSB to MSB, one full-adder cell per bit.
    always_comb begin
        // NOTE: every output and temporary gets a value before the loop, so no path leaves one unassigned and no latch is inferred.
        s     = '0;
        cm    = ci;
        carry = ci;
        for (int i = 0; i < CW; i++) begin
            // NOTE: blocking assignments are deliberate here; carry must update in place so bit i+1 sees bit i's carry in the same evaluation.
            if (i == CW - 1) cm = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds slice k of the
// operands and registers its carry for stage k+1; operands, partial sum and
// valid travel skewed through the pipe so one operation enters per cycle.
// The whole pipe advances together or holds together (valid/ready).
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipe_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Stage inputs (combinational) and stage registers, indexed by stage.
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];
    logic [SW-1:0]     s_ch [STAGES];
    logic [STAGES-1:0] ci_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] co_ch;
    logic [STAGES-1:0] cm_ch;

    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] vld;
    logic              ovf_q;

    logic adv;

    // The pipe moves only when the output slot is empty or being drained.
    assign adv       = !vld[LAST] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // b is conditioned once on entry; the inverted copy travels on.
            assign a_in[k]  = a;
            assign b_in[k]  = sub ? ~b : b;
            assign s_in[k]  = '0;
            assign ci_in[k] = cin;
            assign v_in[k]  = in_valid;
        end else begin : g_body
            assign a_in[k]  = a_q[k-1];
            assign b_in[k]  = b_q[k-1];
            assign s_in[k]  = s_q[k-1];
            assign ci_in[k] = c_q[k-1];
            assign v_in[k]  = vld[k-1];
        end

        addsub_chunk #(.CW(SW)) u_chunk (
            .a  (a_in[k][k*SW +: SW]),
            .b  (b_in[k][k*SW +: SW]),
            .ci (ci_in[k]),
            .s  (s_ch[k]),
            .co (co_ch[k]),
            .cm (cm_ch[k])
        );

        // Slice k of the incoming partial sum is still zero, so OR merges it in.
        assign s_nx[k] = s_in[k] | (WIDTH'(s_ch[k]) << (k * SW));
    end

    // Shift every stage forward on advance, hold everything otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and partial-sum registers are cleared as well, so held result fields are deterministic straight out of reset.
            vld   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking updates let each stage sample its predecessor's pre-edge value, which is what makes this a shift.
            vld   <= v_in;
            c_q   <= co_ch;
            ovf_q <= co_ch[LAST] ^ cm_ch[LAST];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    // Operands leaving the last stage and MSB carries of inner slices are dead.
    logic unused_ok;
    assign unused_ok = ^{a_q[LAST], b_q[LAST], cm_ch};

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, STAGES=4): directed corner
// cases, random streaming, back-pressure and mid-stream reset, checked
// against an arithmetic reference model.
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int W = DEFAULT_WIDTH;
    localparam int S = DEFAULT_STAGES;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned total for sum/cout, signed range test for overflow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic c);
        logic [W:0]   tot;
        logic [W-1:0] yy;
        int           sv;
        res_t         r;
        yy     = s ? ~y : y;
        tot    = {1'b0, x} + {1'b0, yy} + (W+1)'(c);
        r.sum  = tot[W-1:0];
        r.cout = tot[W];
        sv     = int'($signed(x)) + int'($signed(yy)) + int'(c);
        r.ovf  = (sv > (2**(W-1)) - 1) || (sv < -(2**(W-1)));
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.sum  = sum;
        r.cout = cout;
        r.ovf  = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        sub      = s;
        cin      = c;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if ({sum, cout, ovf} !== '0) begin n_fail++; $display("FAIL reset_result: got %h/%b/%b expected 0/0/0", sum, cout, ovf); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s, input logic c, input logic [W-1:0] e_sum,
                               input logic e_cout, input logic e_ovf);
        int cycles;
        drive(1'b1, x, y, s, c);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < S + 4) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || cycles != S) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles (valid=%b) expected %0d", name, cycles, out_valid, S);
        end
        n_checks++;
        if (sum !== e_sum) begin n_fail++; $display("FAIL %s_sum: got %h expected %h", name, sum, e_sum); end
        n_checks++;
        if (cout !== e_cout) begin n_fail++; $display("FAIL %s_cout: got %b expected %b", name, cout, e_cout); end
        n_checks++;
        if (ovf !== e_ovf) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, e_ovf); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_no_dup: got valid %b expected 0", name, out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] xa [8];
        logic [W-1:0] xb [8];
        logic         xs [8];
        logic         xc [8];
        logic         exp_v;
        res_t         exp_r;
        for (int i = 0; i < 8; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xs[i] = 1'($urandom_range(0, 1));
            xc[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        drive(1'b1, xa[0], xb[0], xs[0], xc[0]);
        for (int cyc = 1; cyc <= 8 + S + 1; cyc++) begin
            tick();
            exp_v = (cyc >= S) && (cyc < S + 8);
            n_checks++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL stream_valid_c%0d: got %b expected %b", cyc, out_valid, exp_v);
            end else if (exp_v) begin
                exp_r = model(xa[cyc-S], xb[cyc-S], xs[cyc-S], xc[cyc-S]);
                n_checks++;
                if (observed() !== exp_r) begin
                    n_fail++;
                    $display("FAIL stream_op%0d: got %h expected %h", cyc - S, observed(), exp_r);
                end
            end
            if (cyc < 8) drive(1'b1, xa[cyc], xb[cyc], xs[cyc], xc[cyc]);
            else         drive(1'b0, '0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] xa [5];
        logic [W-1:0] xb [5];
        logic         xs [5];
        logic         xc [5];
        res_t         exp_r;
        for (int i = 0; i < 5; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xs[i] = 1'($urandom_range(0, 1));
            xc[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int i = 0; i < S; i++) begin
            drive(1'b1, xa[i], xb[i], xs[i], xc[i]);
            tick();
        end
        // Pipe full: op0 at the output, op4 offered but must be refused.
        exp_r = model(xa[0], xb[0], xs[0], xc[0]);
        out_ready = 1'b0;
        drive(1'b1, xa[4], xb[4], xs[4], xc[4]);
        for (int h = 0; h < 5; h++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_h%0d: got %b expected 0", h, in_ready); end
            n_checks++;
            if ({out_valid, observed()} !== {1'b1, exp_r}) begin
                n_fail++;
                $display("FAIL bp_hold_h%0d: got %b/%h expected 1/%h", h, out_valid, observed(), exp_r);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        // Release edge pops op0 and pushes op4 at the same time.
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            exp_r = model(xa[i], xb[i], xs[i], xc[i]);
            n_checks++;
            if ({out_valid, observed()} !== {1'b1, exp_r}) begin
                n_fail++;
                $display("FAIL bp_drain_op%0d: got %b/%h expected 1/%h", i, out_valid, observed(), exp_r);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_end: got valid %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < S; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_clear: got %b expected 0", out_valid); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < S + 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_c%0d: got valid %b expected 0", i, out_valid); end
        end
        test_single("rstmid_new", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_single("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_single("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_single("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_single("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_single("sub_bin",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0);
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global guard so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor built from full-adder chunks.
- Each stage adds one WIDTH/STAGES-bit slice of the operands and registers the carry into the next stage.
- Operands and mode travel skewed through the pipe, so one new operation is accepted every cycle.
- Valid/ready handshake on input and output. Sits in the datapath wherever a wide add/sub would otherwise fail timing.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / active-low borrow-in (sub)
- sub  in  1  0: A+B+cin; 1: A+~B+cin (A-B when cin=1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, sum, cout and ovf clear to 0. All partial-sum and carry registers clear to 0. in_ready reflects the advance rule below and does not depend on reset state.
- Advance rule: adv = !out_valid | out_ready. in_ready = adv, combinational. When adv=1 every stage register shifts forward one stage. When adv=0 the whole pipe holds, data and valid alike.
- Accept: the input is captured when in_valid & in_ready. Otherwise a bubble (valid=0) enters stage 0 on advance.
- Stage k (0..STAGES-1) operates on bits [k*CW +: CW]:
  - Operand b is conditionally inverted by sub before entering its chunk.
  - Stage 0 carry-in is cin.
  - Stage k>0 carry-in is the registered carry from stage k-1.
  - Stage k writes its CW result bits into the partial-sum register and passes the remaining upper operand slices forward.
- Latency: exactly STAGES cycles from accept to out_valid with no back-pressure. STAGES=1 gives a single registered full-width adder.
- Throughput: 1 operation per cycle while out_ready=1.
- Final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB, computed with the inverted b as actually added.
- Bubbles never assert out_valid. Result fields under out_valid=0 are don't-care but must be stable while held.
- Simultaneous pop and push when full (out_valid=1, out_ready=1, in_valid=1): the new input is accepted and the pipe advances. No lost or duplicated results.
- Output hold: while out_valid=1 & out_ready=0, sum/cout/ovf/out_valid stay constant and in_ready=0.
- Reset mid-operation: all in-flight operations are discarded. out_valid falls immediately, asynchronously.
- Width wrap: sum is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package/include holds:
  - default WIDTH/STAGES constants;
  - localparam CW = WIDTH/STAGES;
  - an elaboration-time check that WIDTH % STAGES == 0 and STAGES >= 1 (fatal on violation).
- One natural sub-module, addsub_chunk: combinational CW-bit ripple of full-adder cells.
  - Inputs: a, b (already conditioned), ci.
  - Outputs: s, co, and the carry into its MSB (used for ovf in the last chunk).
  - Instantiated STAGES times via generate.
- The pipeline/handshake registers stay in pipe_addsub.

Test Plan (WIDTH=16, STAGES=4):
- Add carry wrap: a=0xFFFF, b=0x0001, sub=0, cin=0, out_ready=1 → after 4 cycles sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0, cin=0 → sum=0x8000, cout=0, ovf=1. Also sub=1, cin=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Borrow: sub=1, cin=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. With cin=0 (borrow-in) → sum=0xFFFD.
- Streaming: 8 back-to-back random ops with out_ready=1 → results emerge in order on 8 consecutive cycles starting cycle 4, all matching a reference model.
- Back-pressure: fill the pipe, hold out_ready=0 for 5 cycles → in_ready=0, outputs frozen. Release → the 4 queued results drain in order with no loss or duplication.
- Reset mid-stream: assert rst with 3 ops in flight → out_valid=0 immediately. After release, no stale result ever appears, and a new op a=0x1234, b=0x1111 returns 0x2345 after 4 cycles.
